// File: rtl/snes_rom_pkg.sv
// Shared types and constants for the SNES ROM loader: FSM states, header layout
// and the packed write-FIFO entry format.
package snes_rom_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
    FLUSH,
    DONE
  } state_t;

  localparam int HDR_LEN = 64;

  localparam int OFS_MAP_MODE  = 'h15;
  localparam int OFS_CART_TYPE = 'h16;
  localparam int OFS_ROM_SIZE  = 'h17;
  localparam int OFS_RAM_SIZE  = 'h18;

  localparam logic [22:0] ROM_MASK_MAX = 23'h7FFFFF;

  // FIFO entry layout is {word address (byte addr[22:1]), din, ds}
  localparam int ENTRY_W = 22 + 16 + 2;

  // Size code N means a 1KB << N ROM; anything past 8MB pins to the full space.
  function automatic logic [22:0] calc_rom_mask(input logic [7:0] code);
    logic [22:0] span;
    if (code >= 8'd13) begin
      return ROM_MASK_MAX;
    end
    span = 23'd1024 << code[3:0];
    return span - 23'd1;
  endfunction

endpackage

// File: rtl/rom_wfifo.sv
// Small synchronous FIFO for packed SDRAM write words. The head entry is read
// straight from the storage flops, so a push is visible no earlier than next cycle.
module rom_wfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/snes_rom_writer.sv
// Streams a ROM image from the IO subsystem into SDRAM: strips and decodes the
// header, packs bytes into 16-bit words and drains them through a write FIFO.
module snes_rom_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int HDR_LEN    = snes_rom_pkg::HDR_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_ds,
  output logic        mem_wr,
  input  logic        mem_wait,
  output logic [7:0]  map_mode,
  output logic [7:0]  cart_type,
  output logic [7:0]  rom_size_code,
  output logic [7:0]  ram_size_code,
  output logic [22:0] rom_mask,
  output logic        header_valid,
  output logic        busy,
  output logic        load_done,
  output logic        overflow,
  output logic [22:0] byte_count
);

  import snes_rom_pkg::*;

  state_t             state_q, state_d;
  logic               loading_q;
  logic               rise, fall;
  logic [15:0]        hdr_cnt_q, hdr_cnt_d;
  logic [7:0]         map_mode_q, map_mode_d;
  logic [7:0]         cart_type_q, cart_type_d;
  logic [7:0]         rom_size_q, rom_size_d;
  logic [7:0]         ram_size_q, ram_size_d;
  logic [22:0]        rom_mask_q, rom_mask_d;
  logic               header_valid_q, header_valid_d;
  logic               overflow_q, overflow_d;
  logic [22:0]        byte_count_q, byte_count_d;
  logic [21:0]        wr_word_q, wr_word_d;
  logic               odd_pending_q, odd_pending_d;
  logic [7:0]         lo_byte_q, lo_byte_d;
  logic               load_done_q, load_done_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_head;

  logic               mem_wr_q, mem_wr_d;
  logic [21:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_din_q, mem_din_d;
  logic [1:0]         mem_ds_q, mem_ds_d;

  assign rise = rom_loading && !loading_q;
  assign fall = !rom_loading && loading_q;

  rom_wfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wfifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      loading_q      <= 1'b0;
      hdr_cnt_q      <= '0;
      map_mode_q     <= '0;
      cart_type_q    <= '0;
      rom_size_q     <= '0;
      ram_size_q     <= '0;
      rom_mask_q     <= '0;
      header_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      byte_count_q   <= '0;
      wr_word_q      <= '0;
      odd_pending_q  <= 1'b0;
      lo_byte_q      <= '0;
      load_done_q    <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      mem_ds_q       <= '0;
    end else begin
      state_q        <= state_d;
      loading_q      <= rom_loading;
      hdr_cnt_q      <= hdr_cnt_d;
      map_mode_q     <= map_mode_d;
      cart_type_q    <= cart_type_d;
      rom_size_q     <= rom_size_d;
      ram_size_q     <= ram_size_d;
      rom_mask_q     <= rom_mask_d;
      header_valid_q <= header_valid_d;
      overflow_q     <= overflow_d;
      byte_count_q   <= byte_count_d;
      wr_word_q      <= wr_word_d;
      odd_pending_q  <= odd_pending_d;
      lo_byte_q      <= lo_byte_d;
      load_done_q    <= load_done_d;
      mem_wr_q       <= mem_wr_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      mem_ds_q       <= mem_ds_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    map_mode_d     = map_mode_q;
    cart_type_d    = cart_type_q;
    rom_size_d     = rom_size_q;
    ram_size_d     = ram_size_q;
    rom_mask_d     = rom_mask_q;
    header_valid_d = header_valid_q;
    overflow_d     = overflow_q;
    byte_count_d   = byte_count_q;
    wr_word_d      = wr_word_q;
    odd_pending_d  = odd_pending_q;
    lo_byte_d      = lo_byte_q;
    fifo_push      = 1'b0;
    fifo_wdata     = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (rise) begin
          state_d        = HEADER;
          hdr_cnt_d      = '0;
          header_valid_d = 1'b0;
          overflow_d     = 1'b0;
          byte_count_d   = '0;
          wr_word_d      = '0;
          odd_pending_d  = 1'b0;
        end
      end
      HEADER: begin
        if (fall) begin
          state_d = IDLE;
        end else if (rom_do_valid) begin
          if (hdr_cnt_q == 16'(OFS_MAP_MODE))  map_mode_d  = rom_do;
          if (hdr_cnt_q == 16'(OFS_CART_TYPE)) cart_type_d = rom_do;
          if (hdr_cnt_q == 16'(OFS_RAM_SIZE))  ram_size_d  = rom_do;
          if (hdr_cnt_q == 16'(OFS_ROM_SIZE)) begin
            rom_size_d = rom_do;
            rom_mask_d = calc_rom_mask(rom_do);
          end
          hdr_cnt_d = hdr_cnt_q + 16'd1;
          if (hdr_cnt_q == 16'(HDR_LEN - 1)) begin
            state_d        = DATA;
            header_valid_d = 1'b1;
          end
        end
      end
      DATA: begin
        // Bytes that find the FIFO full are lost entirely so even/odd pairing stays intact
        if (rom_do_valid) begin
          if (fifo_full) begin
            overflow_d = 1'b1;
          end else begin
            byte_count_d = byte_count_q + 23'd1;
            if (odd_pending_q) begin
              fifo_push     = 1'b1;
              fifo_wdata    = {wr_word_q, rom_do, lo_byte_q, 2'b11};
              wr_word_d     = wr_word_q + 22'd1;
              odd_pending_d = 1'b0;
            end else begin
              lo_byte_d     = rom_do;
              odd_pending_d = 1'b1;
            end
          end
        end
        if (fall) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (odd_pending_q) begin
          if (!fifo_full) begin
            fifo_push     = 1'b1;
            fifo_wdata    = {wr_word_q, 8'h00, lo_byte_q, 2'b01};
            wr_word_d     = wr_word_q + 22'd1;
            odd_pending_d = 1'b0;
          end
        end else if (fifo_empty && !mem_wr_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    load_done_d = (state_d == DONE) && (state_q != DONE);
  end

  // Write engine: one outstanding request, dropped for a cycle after every accept
  always_comb begin
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_ds_d   = mem_ds_q;
    fifo_pop   = 1'b0;
    if (mem_wr_q) begin
      if (!mem_wait) begin
        fifo_pop = 1'b1;
        mem_wr_d = 1'b0;
      end
    end else if (!fifo_empty) begin
      mem_wr_d                            = 1'b1;
      {mem_addr_d, mem_din_d, mem_ds_d} = fifo_head;
    end
  end

  assign mem_addr      = {mem_addr_q, 1'b0};
  assign mem_din       = mem_din_q;
  assign mem_ds        = mem_ds_q;
  assign mem_wr        = mem_wr_q;
  assign map_mode      = map_mode_q;
  assign cart_type     = cart_type_q;
  assign rom_size_code = rom_size_q;
  assign ram_size_code = ram_size_q;
  assign rom_mask      = rom_mask_q;
  assign header_valid  = header_valid_q;
  assign busy          = (state_q == HEADER) || (state_q == DATA) || (state_q == FLUSH);
  assign load_done     = load_done_q;
  assign overflow      = overflow_q;
  assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_snes_rom_writer.sv
// Self-checking bench for snes_rom_writer: a byte-level model predicts every
// SDRAM write into a queue that a monitor drains as writes are accepted.
module tb_snes_rom_writer;

  localparam int FIFO_DEPTH = 8;
  localparam int HDR_LEN    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_loading = 1'b0;
  logic [7:0]  rom_do = 8'h00;
  logic        rom_do_valid = 1'b0;
  logic        mem_wait = 1'b0;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_wr;
  logic [7:0]  map_mode, cart_type, rom_size_code, ram_size_code;
  logic [22:0] rom_mask;
  logic        header_valid, busy, load_done, overflow;
  logic [22:0] byte_count;

  typedef struct {
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
  } wr_t;

  wr_t         expQ[$];
  int          tests = 0;
  int          failed = 0;
  int          wrCount = 0;
  int          loadDoneCount = 0;
  logic        randWait = 1'b0;
  logic        prevWr = 1'b0;
  logic        prevWait = 1'b0;
  logic [22:0] prevAddr = '0;
  logic [15:0] prevDin = '0;
  logic [1:0]  prevDs = '0;
  logic [22:0] modelAddr = '0;
  logic [7:0]  modelLo = '0;
  logic        modelOdd = 1'b0;

  snes_rom_writer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HDR_LEN    (HDR_LEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_loading   (rom_loading),
    .rom_do        (rom_do),
    .rom_do_valid  (rom_do_valid),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_ds        (mem_ds),
    .mem_wr        (mem_wr),
    .mem_wait      (mem_wait),
    .map_mode      (map_mode),
    .cart_type     (cart_type),
    .rom_size_code (rom_size_code),
    .ram_size_code (ram_size_code),
    .rom_mask      (rom_mask),
    .header_valid  (header_valid),
    .busy          (busy),
    .load_done     (load_done),
    .overflow      (overflow),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (randWait) mem_wait = 1'($urandom_range(0, 1));
  end

  // Monitor: handshake hold/gap rules and scoreboard pop on every accepted write
  always @(negedge clk) begin
    if (load_done) loadDoneCount++;
    if (reset) begin
      prevWr   = 1'b0;
      prevWait = 1'b0;
    end else begin
      if (prevWr && prevWait) begin
        tests++;
        if (mem_wr !== 1'b1 || mem_addr !== prevAddr || mem_din !== prevDin || mem_ds !== prevDs) begin
          failed++;
          $display("[TB] FAIL hold_stable: wr=%b addr=%h din=%h ds=%b, required wr=1 addr=%h din=%h ds=%b",
                   mem_wr, mem_addr, mem_din, mem_ds, prevAddr, prevDin, prevDs);
        end
      end
      if (prevWr && !prevWait) begin
        tests++;
        if (mem_wr !== 1'b0) begin
          failed++;
          $display("[TB] FAIL wr_gap: mem_wr=%b, required 0", mem_wr);
        end
      end
      if (mem_wr && !mem_wait) begin
        wrCount++;
        tests++;
        if (expQ.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected_write: addr=%h din=%h ds=%b, required none", mem_addr, mem_din, mem_ds);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          if (mem_addr !== e.addr || mem_ds !== e.ds ||
              (e.ds == 2'b11 && mem_din !== e.din) || mem_din[7:0] !== e.din[7:0]) begin
            failed++;
            $display("[TB] FAIL write_data: addr=%h din=%h ds=%b, required addr=%h din=%h ds=%b",
                     mem_addr, mem_din, mem_ds, e.addr, e.din, e.ds);
          end
        end
      end
      prevWr   = mem_wr;
      prevWait = mem_wait;
      prevAddr = mem_addr;
      prevDin  = mem_din;
      prevDs   = mem_ds;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelByte(input logic [7:0] b);
    wr_t e;
    if (modelOdd) begin
      e.addr = modelAddr;
      e.din  = {b, modelLo};
      e.ds   = 2'b11;
      expQ.push_back(e);
      modelAddr = modelAddr + 23'd2;
      modelOdd  = 1'b0;
    end else begin
      modelLo  = b;
      modelOdd = 1'b1;
    end
  endtask

  task automatic applyByte(input logic [7:0] b);
    rom_do       = b;
    rom_do_valid = 1'b1;
    @(posedge clk);
    #1;
    rom_do_valid = 1'b0;
  endtask

  task automatic startLoad();
    rom_loading = 1'b1;
    idleCycle();
    modelAddr = '0;
    modelOdd  = 1'b0;
  endtask

  task automatic endLoad();
    wr_t e;
    rom_loading = 1'b0;
    idleCycle();
    if (modelOdd) begin
      e.addr = modelAddr;
      e.din  = {8'h00, modelLo};
      e.ds   = 2'b01;
      expQ.push_back(e);
      modelOdd = 1'b0;
    end
  endtask

  task automatic sendHeader(input logic [7:0] mm, input logic [7:0] ct,
                            input logic [7:0] rs, input logic [7:0] rm, input int nBytes);
    logic [7:0] b;
    for (int i = 0; i < nBytes; i++) begin
      b = 8'(i * 7 + 3);
      if (i == 'h15) b = mm;
      if (i == 'h16) b = ct;
      if (i == 'h17) b = rs;
      if (i == 'h18) b = rm;
      if (i == HDR_LEN - 1) begin
        tests++;
        if (header_valid !== 1'b0) begin
          failed++;
          $display("[TB] FAIL hv_before_last: header_valid=%b, required 0", header_valid);
        end
      end
      applyByte(b);
      if (i == HDR_LEN - 1) begin
        tests++;
        if (header_valid !== 1'b1) begin
          failed++;
          $display("[TB] FAIL hv_after_last: header_valid=%b, required 1", header_valid);
        end
      end
      if (i % 4 == 3) idleCycle();
    end
  endtask

  task automatic sendData(input int n, input logic [7:0] base, input logic [7:0] step, input int acceptLimit);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(base + 8'(i) * step);
      applyByte(b);
      if (i < acceptLimit) modelByte(b);
      if (i % 4 == 3) idleCycle();
    end
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL load_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
    repeat (3) idleCycle();
  endtask

  task automatic test_reset();
    tests++;
    if (mem_wr !== 1'b0) begin failed++; $display("[TB] FAIL rst_mem_wr: %b, required 0", mem_wr); end
    tests++;
    if (mem_addr !== 23'h0) begin failed++; $display("[TB] FAIL rst_mem_addr: %h, required 0", mem_addr); end
    tests++;
    if (busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_busy: %b, required 0", busy); end
    tests++;
    if (header_valid !== 1'b0) begin failed++; $display("[TB] FAIL rst_hv: %b, required 0", header_valid); end
    tests++;
    if (rom_mask !== 23'h0) begin failed++; $display("[TB] FAIL rst_rom_mask: %h, required 0", rom_mask); end
    tests++;
    if ({overflow, load_done, byte_count} !== 25'h0) begin
      failed++;
      $display("[TB] FAIL rst_status: ovf=%b done=%b cnt=%h, required 0", overflow, load_done, byte_count);
    end
  endtask

  task automatic test_basic_load();
    int ld0, wr0;
    ld0 = loadDoneCount;
    wr0 = wrCount;
    startLoad();
    tests++;
    if (busy !== 1'b1) begin failed++; $display("[TB] FAIL basic_busy: %b, required 1", busy); end
    sendHeader(8'h21, 8'h35, 8'h0C, 8'h03, HDR_LEN);
    sendData(4, 8'hAA, 8'h11, 100);
    endLoad();
    waitIdle(200);
    tests++;
    if (map_mode !== 8'h21) begin failed++; $display("[TB] FAIL basic_map_mode: %h, required 21", map_mode); end
    tests++;
    if (cart_type !== 8'h35 || ram_size_code !== 8'h03 || rom_size_code !== 8'h0C) begin
      failed++;
      $display("[TB] FAIL basic_hdr_fields: ct=%h ram=%h rom=%h, required 35 03 0C", cart_type, ram_size_code, rom_size_code);
    end
    tests++;
    if (rom_mask !== 23'h3FFFFF) begin failed++; $display("[TB] FAIL basic_rom_mask: %h, required 3FFFFF", rom_mask); end
    tests++;
    if (byte_count !== 23'd4) begin failed++; $display("[TB] FAIL basic_byte_count: %0d, required 4", byte_count); end
    tests++;
    if (wrCount - wr0 !== 2 || expQ.size() !== 0) begin
      failed++;
      $display("[TB] FAIL basic_writes: seen=%0d pending=%0d, required 2 and 0", wrCount - wr0, expQ.size());
    end
    tests++;
    if (loadDoneCount - ld0 !== 1) begin failed++; $display("[TB] FAIL basic_load_done: %0d pulses, required 1", loadDoneCount - ld0); end
    tests++;
    if (overflow !== 1'b0) begin failed++; $display("[TB] FAIL basic_overflow: %b, required 0", overflow); end
  endtask

  task automatic test_odd_flush();
    int ld0, wr0;
    ld0 = loadDoneCount;
    wr0 = wrCount;
    randWait = 1'b1;
    startLoad();
    sendHeader(8'h20, 8'h00, 8'h08, 8'h00, HDR_LEN);
    sendData(3, 8'h01, 8'h01, 100);
    endLoad();
    waitIdle(300);
    randWait = 1'b0;
    mem_wait = 1'b0;
    tests++;
    if (byte_count !== 23'd3) begin failed++; $display("[TB] FAIL odd_byte_count: %0d, required 3", byte_count); end
    tests++;
    if (wrCount - wr0 !== 2 || expQ.size() !== 0) begin
      failed++;
      $display("[TB] FAIL odd_writes: seen=%0d pending=%0d, required 2 and 0", wrCount - wr0, expQ.size());
    end
    tests++;
    if (loadDoneCount - ld0 !== 1) begin failed++; $display("[TB] FAIL odd_load_done: %0d pulses, required 1", loadDoneCount - ld0); end
  endtask

  task automatic test_overflow();
    int wr0;
    wr0 = wrCount;
    mem_wait = 1'b1;
    startLoad();
    sendHeader(8'h21, 8'h02, 8'h0A, 8'h01, HDR_LEN);
    sendData(24, 8'h10, 8'h01, 2 * FIFO_DEPTH);
    repeat (10) idleCycle();
    tests++;
    if (overflow !== 1'b1) begin failed++; $display("[TB] FAIL ovf_flag: %b, required 1", overflow); end
    tests++;
    if (byte_count !== 23'(2 * FIFO_DEPTH)) begin
      failed++;
      $display("[TB] FAIL ovf_byte_count: %0d, required %0d", byte_count, 2 * FIFO_DEPTH);
    end
    tests++;
    if (mem_wr !== 1'b1 || mem_addr !== 23'h0 || mem_din !== 16'h1110) begin
      failed++;
      $display("[TB] FAIL ovf_held_write: wr=%b addr=%h din=%h, required 1 0 1110", mem_wr, mem_addr, mem_din);
    end
    mem_wait = 1'b0;
    endLoad();
    waitIdle(300);
    tests++;
    if (wrCount - wr0 !== FIFO_DEPTH || expQ.size() !== 0) begin
      failed++;
      $display("[TB] FAIL ovf_drain: seen=%0d pending=%0d, required %0d and 0", wrCount - wr0, expQ.size(), FIFO_DEPTH);
    end
    tests++;
    if (overflow !== 1'b1) begin failed++; $display("[TB] FAIL ovf_sticky: %b, required 1", overflow); end
  endtask

  task automatic test_header_abort();
    int ld0, wr0;
    ld0 = loadDoneCount;
    wr0 = wrCount;
    startLoad();
    sendHeader(8'h21, 8'h00, 8'h0C, 8'h00, 10);
    rom_loading = 1'b0;
    repeat (5) idleCycle();
    tests++;
    if (busy !== 1'b0 || header_valid !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_state: busy=%b hv=%b, required 0 0", busy, header_valid);
    end
    tests++;
    if (wrCount - wr0 !== 0 || loadDoneCount - ld0 !== 0) begin
      failed++;
      $display("[TB] FAIL abort_activity: writes=%0d done=%0d, required 0 0", wrCount - wr0, loadDoneCount - ld0);
    end
  endtask

  task automatic test_rom_mask();
    logic [7:0]  codes [4] = '{8'h00, 8'h0C, 8'h0D, 8'h0F};
    logic [22:0] expMask;
    for (int k = 0; k < 4; k++) begin
      startLoad();
      sendHeader(8'h20, 8'h00, codes[k], 8'h00, HDR_LEN);
      endLoad();
      waitIdle(100);
      expMask = (codes[k] >= 8'd13) ? 23'h7FFFFF : 23'((24'd1024 << codes[k]) - 24'd1);
      tests++;
      if (rom_mask !== expMask) begin
        failed++;
        $display("[TB] FAIL rom_mask_code_%h: %h, required %h", codes[k], rom_mask, expMask);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    mem_wait = 1'b1;
    startLoad();
    sendHeader(8'h31, 8'h02, 8'h0A, 8'h01, HDR_LEN);
    sendData(2, 8'h55, 8'h01, 100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_wr) break;
    end
    tests++;
    if (mem_wr !== 1'b1) begin failed++; $display("[TB] FAIL midwr_pending: mem_wr=%b, required 1", mem_wr); end
    idleCycle();
    reset       = 1'b1;
    rom_loading = 1'b0;
    mem_wait    = 1'b0;
    idleCycle();
    tests++;
    if (mem_wr !== 1'b0) begin failed++; $display("[TB] FAIL midwr_drop: mem_wr=%b, required 0", mem_wr); end
    tests++;
    if ({mem_addr, mem_din, mem_ds, map_mode, cart_type, rom_size_code, ram_size_code,
         rom_mask, header_valid, busy, load_done, overflow, byte_count} !== '0) begin
      failed++;
      $display("[TB] FAIL midwr_outputs: addr=%h din=%h ds=%b mm=%h mask=%h hv=%b busy=%b cnt=%h, required all 0",
               mem_addr, mem_din, mem_ds, map_mode, rom_mask, header_valid, busy, byte_count);
    end
    idleCycle();
    reset = 1'b0;
    expQ.delete();
    repeat (5) idleCycle();
    tests++;
    if (mem_wr !== 1'b0 || busy !== 1'b0) begin
      failed++;
      $display("[TB] FAIL midwr_after: mem_wr=%b busy=%b, required 0 0", mem_wr, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idleCycle();
    test_reset();
    test_basic_load();
    test_odd_flush();
    test_overflow();
    test_header_abort();
    test_rom_mask();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
